// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh terminal path: default sizes, packet
// typedefs and the packet field layout used by the mesh and the test agents.
//
// Packet layout (MSB first): dst_row | dst_col | mode | payload
package mesh_pkg;

    localparam int unsigned PCKG_SZ = 40;
    localparam int unsigned NTRMS   = 16;

    typedef logic [PCKG_SZ-1:0]  pckg_t;
    typedef pckg_t [NTRMS-1:0]   pckg_arr_t;

    // Packet field layout
    localparam int unsigned ROW_W    = 4;
    localparam int unsigned COL_W    = 4;
    localparam int unsigned MODE_W   = 1;
    localparam int unsigned PYLD_W   = PCKG_SZ - ROW_W - COL_W - MODE_W;
    localparam int unsigned PYLD_LSB = 0;
    localparam int unsigned MODE_LSB = PYLD_LSB + PYLD_W;
    localparam int unsigned COL_LSB  = MODE_LSB + MODE_W;
    localparam int unsigned ROW_LSB  = COL_LSB + COL_W;

    function automatic pckg_t mk_pckg(
        input logic [ROW_W-1:0]  row,
        input logic [COL_W-1:0]  col,
        input logic              mode,
        input logic [PYLD_W-1:0] pyld
    );
        return {row, col, mode, pyld};
    endfunction

endpackage

// File: rtl/mesh_chnl_fifo.sv
// Single-channel first-word-fall-through FIFO feeding one mesh terminal.
// Carries the push/pop handshake, full/almost-full flags and a sticky drop
// flag for pushes discarded while full.
//
// Ports:
//   clk, reset (async, active-low)
//   push, data_in     : write strobe and packet from the agent
//   popin             : mesh consumes the head
//   clr_drop          : clears the sticky drop flag
//   data_out, pndng   : head packet and head-valid toward the mesh
//   full, afull, drop : occupancy flags and sticky overflow flag
module mesh_chnl_fifo #(
    parameter int unsigned PCKG_SZ  = mesh_pkg::PCKG_SZ,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AFULL_TH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [PCKG_SZ-1:0] data_in,
    input  logic               popin,
    input  logic               clr_drop,
    output logic [PCKG_SZ-1:0] data_out,
    output logic               pndng,
    output logic               full,
    output logic               afull,
    output logic               drop
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PCKG_SZ-1:0] ram [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic               drop_q;
    logic               pop_ok;
    logic               push_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pndng    = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign afull    = (count >= CW'(AFULL_TH));
    assign data_out = ram[rd_ptr];
    assign drop     = drop_q;

    // Pop is gated by pndng, so push+pop on an empty channel is a plain push.
    // A same-cycle pop frees the slot a push into a full channel needs.
    assign pop_ok  = popin && pndng;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ram[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            drop_q <= 1'b0;
        end else begin
            if (push_ok) begin
                ram[wr_ptr] <= data_in;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (!push_ok && pop_ok) begin
                count <= count - CW'(1);
            end
            // Set has priority over clear.
            if (push && !push_ok) begin
                drop_q <= 1'b1;
            end else if (clr_drop) begin
                drop_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mesh_term_buffer.sv
// Per-terminal ingress buffer bank between the test agents and the
// mesh_gnrtr terminal inputs: NTRMS independent FIFOs, each drained through
// the pndng_i_in / data_out_i_in / popin handshake.
//
// Ports (all per channel, index = terminal):
//   clk, reset (async, active-low)
//   push, data_in         : agent write strobe and packet
//   data_out_i_in         : head packet presented to the mesh terminal
//   pndng_i_in            : channel non-empty
//   popin                 : mesh consumes the head
//   full, afull           : occupancy == DEPTH, occupancy >= AFULL_TH
//   drop, clr_drop        : sticky discarded-push flag and its clear
module mesh_term_buffer #(
    parameter int unsigned NTRMS    = mesh_pkg::NTRMS,
    parameter int unsigned PCKG_SZ  = mesh_pkg::PCKG_SZ,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AFULL_TH = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NTRMS-1:0]                push,
    input  logic [NTRMS-1:0][PCKG_SZ-1:0]   data_in,
    output logic [NTRMS-1:0][PCKG_SZ-1:0]   data_out_i_in,
    output logic [NTRMS-1:0]                pndng_i_in,
    input  logic [NTRMS-1:0]                popin,
    output logic [NTRMS-1:0]                full,
    output logic [NTRMS-1:0]                afull,
    output logic [NTRMS-1:0]                drop,
    input  logic [NTRMS-1:0]                clr_drop
);

    for (genvar g = 0; g < int'(NTRMS); g++) begin : g_chnl
        mesh_chnl_fifo #(
            .PCKG_SZ  (PCKG_SZ),
            .DEPTH    (DEPTH),
            .AFULL_TH (AFULL_TH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push[g]),
            .data_in  (data_in[g]),
            .popin    (popin[g]),
            .clr_drop (clr_drop[g]),
            .data_out (data_out_i_in[g]),
            .pndng    (pndng_i_in[g]),
            .full     (full[g]),
            .afull    (afull[g]),
            .drop     (drop[g])
        );
    end

endmodule

// File: tb/tb_mesh_term_buffer.sv
module tb_mesh_term_buffer;
    import mesh_pkg::*;

    localparam int unsigned NT    = NTRMS;
    localparam int unsigned PW    = PCKG_SZ;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFT   = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NT-1:0]          push;
    logic [NT-1:0][PW-1:0]  data_in;
    logic [NT-1:0][PW-1:0]  data_out_i_in;
    logic [NT-1:0]          pndng_i_in;
    logic [NT-1:0]          popin;
    logic [NT-1:0]          full;
    logic [NT-1:0]          afull;
    logic [NT-1:0]          drop;
    logic [NT-1:0]          clr_drop;

    int total = 0;
    int bad   = 0;

    // Reference model: one queue of packets per channel plus a drop bit.
    logic [PW-1:0] mq [NT][$];
    bit            mdrop [NT];

    mesh_term_buffer #(
        .NTRMS    (NT),
        .PCKG_SZ  (PW),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .data_in       (data_in),
        .data_out_i_in (data_out_i_in),
        .pndng_i_in    (pndng_i_in),
        .popin         (popin),
        .full          (full),
        .afull         (afull),
        .drop          (drop),
        .clr_drop      (clr_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_vec(input string tag, input logic [NT-1:0] obs, input logic [NT-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pkt(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < int'(NT); c++) begin
            mq[c].delete();
            mdrop[c] = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int c = 0; c < int'(NT); c++) begin
            bit po;
            bit pu;
            po = popin[c] && (mq[c].size() != 0);
            pu = push[c] && ((mq[c].size() < int'(DEPTH)) || po);
            if (po) void'(mq[c].pop_front());
            if (pu) mq[c].push_back(data_in[c]);
            if (push[c] && !pu) mdrop[c] = 1'b1;
            else if (clr_drop[c]) mdrop[c] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [NT-1:0] ep, ef, ea, ed;
        for (int c = 0; c < int'(NT); c++) begin
            ep[c] = (mq[c].size() != 0);
            ef[c] = (mq[c].size() == int'(DEPTH));
            ea[c] = (mq[c].size() >= int'(AFT));
            ed[c] = mdrop[c];
        end
        chk_vec({tag, ":pndng"}, pndng_i_in, ep);
        chk_vec({tag, ":full"},  full,       ef);
        chk_vec({tag, ":afull"}, afull,      ea);
        chk_vec({tag, ":drop"},  drop,       ed);
        for (int c = 0; c < int'(NT); c++) begin
            if (mq[c].size() != 0)
                chk_pkt($sformatf("%s:head%0d", tag, c), data_out_i_in[c], mq[c][0]);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk_vec({tag, ":pndng0"}, pndng_i_in, '0);
        chk_vec({tag, ":full0"},  full,       '0);
        chk_vec({tag, ":afull0"}, afull,      '0);
        chk_vec({tag, ":drop0"},  drop,       '0);
        for (int c = 0; c < int'(NT); c++)
            chk_pkt($sformatf("%s:data0_%0d", tag, c), data_out_i_in[c], '0);
    endtask

    // One clock edge with the currently driven inputs, then idle inputs.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_update();
        #1;
        push     = '0;
        popin    = '0;
        clr_drop = '0;
        check_all(tag);
    endtask

    task automatic fill(input int c, input logic [PW-1:0] base);
        for (int i = 0; i < int'(DEPTH); i++) begin
            push[c]    = 1'b1;
            data_in[c] = base + PW'(i);
            cycle("fill");
        end
    endtask

    initial begin
        push     = '0;
        popin    = '0;
        clr_drop = '0;
        data_in  = '0;
        model_clear();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 check_reset_state("por");
        @(negedge clk) reset = 1'b1;

        // 1: single push on ch0, visible on the next edge
        push[0]    = 1'b1;
        data_in[0] = 40'hA5_0000_0001;
        cycle("t1");
        chk_pkt("t1_head", data_out_i_in[0], 40'hA5_0000_0001);
        chk_vec("t1_pndng", pndng_i_in, 16'h0001);

        // 2: fill ch3 to full, then drain in order
        for (int i = 1; i <= 4; i++) begin
            push[3]    = 1'b1;
            data_in[3] = PW'(i);
            cycle("t2push");
            if (i == 3) begin
                chk_bit("t2_afull3", afull[3], 1'b1);
                chk_bit("t2_notfull3", full[3], 1'b0);
            end
        end
        chk_bit("t2_full3", full[3], 1'b1);
        for (int i = 1; i <= 4; i++) begin
            chk_pkt("t2_order", data_out_i_in[3], PW'(i));
            popin[3] = 1'b1;
            cycle("t2pop");
        end
        chk_bit("t2_empty3", pndng_i_in[3], 1'b0);

        // 3: overflow on ch5, clear, and set-wins-over-clear
        fill(5, 40'h50);
        push[5]    = 1'b1;
        data_in[5] = 40'h99;
        cycle("t3ovf");
        chk_bit("t3_drop", drop[5], 1'b1);
        chk_pkt("t3_head_kept", data_out_i_in[5], 40'h50);
        clr_drop[5] = 1'b1;
        cycle("t3clr");
        chk_bit("t3_drop_clr", drop[5], 1'b0);
        push[5]     = 1'b1;
        data_in[5]  = 40'h99;
        clr_drop[5] = 1'b1;
        cycle("t3both");
        chk_bit("t3_set_wins", drop[5], 1'b1);

        // 4: full ch7, push and pop together
        fill(7, 40'h71);
        push[7]    = 1'b1;
        data_in[7] = 40'h55;
        popin[7]   = 1'b1;
        cycle("t4pp");
        chk_bit("t4_full", full[7], 1'b1);
        chk_pkt("t4_adv", data_out_i_in[7], 40'h72);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk_pkt("t4_last", data_out_i_in[7], 40'h55);
            popin[7] = 1'b1;
            cycle("t4pop");
        end
        chk_bit("t4_nodrop", drop[7], 1'b0);
        chk_bit("t4_empty", pndng_i_in[7], 1'b0);

        // 5: ch2 pop while empty, then push+pop on empty
        popin[2] = 1'b1;
        cycle("t5pop");
        chk_bit("t5_still_empty", pndng_i_in[2], 1'b0);
        push[2]    = 1'b1;
        popin[2]   = 1'b1;
        data_in[2] = 40'h2222;
        cycle("t5pp");
        chk_pkt("t5_head", data_out_i_in[2], 40'h2222);
        chk_bit("t5_afull", afull[2], 1'b0);

        // 6: reset mid-operation flushes everything
        for (int i = 0; i < 3; i++) begin
            push[1]    = 1'b1;
            data_in[1] = 40'hB0 + PW'(i);
            cycle("t6push");
        end
        @(negedge clk) reset = 1'b0;
        #1;
        model_clear();
        check_reset_state("t6rst");
        repeat (2) @(posedge clk);
        #1 check_reset_state("t6hold");
        @(negedge clk) reset = 1'b1;
        push[1]    = 1'b1;
        data_in[1] = 40'h7;
        cycle("t6post");
        chk_pkt("t6_head", data_out_i_in[1], 40'h7);
        popin[1] = 1'b1;
        cycle("t6pop");
        chk_bit("t6_empty", pndng_i_in[1], 1'b0);

        // Randomized traffic on all channels
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < int'(NT); c++) begin
                push[c]     = ($urandom_range(0, 99) < 55);
                popin[c]    = ($urandom_range(0, 99) < 45);
                clr_drop[c] = ($urandom_range(0, 99) < 10);
                data_in[c]  = mk_pckg(4'($urandom), 4'($urandom), 1'($urandom), 31'($urandom));
            end
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mesh_term_buffer.md
Name: mesh_term_buffer

Overview:
- Parametrised per-terminal ingress buffer bank between the test agents and the mesh_gnrtr terminal inputs.
- Holds NTRMS independent FIFOs. Agents push packets into them; the mesh drains each one through the existing pndng_i_in / data_out_i_in / popin handshake.
- Adds what a bare terminal connection lacks: configurable depth, almost-full back-pressure, and sticky overflow flags per terminal.

Parameters:
- NTRMS, 16, number of mesh terminals (channels).
- PCKG_SZ, 40, packet width in bits.
- DEPTH, 4, entries per channel FIFO; must be at least 2.
- AFULL_TH, 3, occupancy at or above which afull asserts; range 1..DEPTH.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- push  in  NTRMS  per-channel write strobe from agent.
- data_in  in  NTRMS x PCKG_SZ  per-channel write packet.
- data_out_i_in  out  NTRMS x PCKG_SZ  head packet presented to mesh terminal.
- pndng_i_in  out  NTRMS  channel non-empty; head valid.
- popin  in  NTRMS  mesh consumes head of channel.
- full  out  NTRMS  occupancy == DEPTH.
- afull  out  NTRMS  occupancy >= AFULL_TH.
- drop  out  NTRMS  sticky: a push was discarded on this channel.
- clr_drop  in  NTRMS  clears the drop flag of the channel.

Behaviour:
- Channels are fully independent. Every rule below applies per channel.

Storage and pointers:
- DEPTH-entry RAM, wrapping read and write pointers, and an occupancy count of width $clog2(DEPTH+1).
- Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.

Head presentation (first-word-fall-through):
- data_out_i_in is driven from RAM[rd_ptr]; pndng_i_in = (count != 0).
- Registered path only; no combinational path from push or data_in to any output.

Latency:
- A push into an empty channel makes pndng_i_in rise on the next edge, with data_out_i_in equal to the pushed packet.
- A pop advances the head on the next edge.

Handshake rules:
- Pop accepted iff popin && pndng_i_in. popin while empty is ignored: no state change, no error.
- Push accepted iff push && (!full || pop accepted in the same cycle).
- Push while full with no same-cycle pop is discarded: RAM, pointers and count unchanged, drop set on the next edge.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- Simultaneous push and pop on an empty channel: pop ignored, push accepted, count becomes 1.

Flags:
- full = (count == DEPTH), afull = (count >= AFULL_TH). Both derive from the registered count.
- drop: set on a discarded push, cleared by clr_drop. When both occur in the same cycle, set wins.

Reset:
- While reset == 0: count 0, pointers 0, RAM cleared to 0.
- Resulting outputs: pndng_i_in 0, data_out_i_in 0, full 0, afull 0, drop 0.
- Reset asserted mid-operation discards all queued packets at once. The first push after deassertion lands in entry 0.

Decomposition:
- Shared package mesh_pkg holds:
  - PCKG_SZ and NTRMS defaults;
  - typedef pckg_t (logic [PCKG_SZ-1:0]);
  - typedef pckg_arr_t (packed NTRMS x pckg_t);
  - the packet field layout constants (destination row/column, mode, payload) used by the mesh and the test agents.
- One sub-module, mesh_chnl_fifo: a single-channel FIFO carrying all handshake, flag and drop logic.
- mesh_term_buffer instantiates NTRMS copies in a generate loop and slices the packed ports.

Test Plan:
1. Reset, then push ch0 = 40'hA5_0000_0001 for one cycle -> next edge: pndng_i_in[0]=1, data_out_i_in[0]=40'hA5_0000_0001. All other channels: pndng 0.
2. Push 4 packets 1..4 on ch3, no pops -> afull[3]=1 after the 3rd push, full[3]=1 after the 4th. Then popin 4 cycles -> heads seen in order 1,2,3,4, then pndng_i_in[3]=0.
3. ch5 full; push 40'h99 with no pop -> drop[5]=1, contents unchanged. clr_drop[5] -> drop[5]=0. clr_drop and an overflow in the same cycle -> drop stays 1.
4. ch7 full; push 40'h55 and popin in the same cycle -> full[7] stays 1, head advances, 40'h55 is dequeued last after 4 more pops, drop[7]=0.
5. ch2 empty; popin alone -> no change. push + popin together -> count 1, head = pushed value.
6. Push 3 packets on ch1, assert reset low mid-cycle for 2 cycles -> all outputs 0 immediately. Push 40'h7 after release -> it is the head; the stale packets never appear.
